// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bundle. The master issues address phases;
// the slave returns addr_ok, data_ok and rdata.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between the read-only inst requester and the data requester.
// Accepted transactions are tracked in an in-order source FIFO to route responses back.
module sram_like_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter bit          DATA_PRIO   = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  sram_like_arbiter_if.slave inst_if,
  sram_like_arbiter_if.slave data_if,
  sram_like_arbiter_if.master m_if,
  output logic               busy
);
  localparam int unsigned PtrW = $clog2(OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StHoldI, StHoldD} state_e;

  state_e                 state_q, state_d;
  logic [OUTSTANDING-1:0] src_q;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   busy_q;
  logic                   full, grant, grant_data, push, pop, head;

  assign busy = busy_q;

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_data = 1'b0;
    // The full check uses the registered count, so a same-cycle pop never frees a slot.
    full       = (cnt_q == CntFull);
    unique case (state_q)
      StIdle: begin
        if (!full && (inst_if.req || data_if.req)) begin
          grant      = 1'b1;
          grant_data = data_if.req && (DATA_PRIO || !inst_if.req);
        end
      end
      StHoldI: begin
        if (!inst_if.req) state_d = StIdle;
        else if (!full)   grant   = 1'b1;
      end
      StHoldD: begin
        grant_data = 1'b1;
        if (!data_if.req) state_d = StIdle;
        else if (!full)   grant   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (grant) begin
      if (m_if.addr_ok) state_d = StIdle;
      else              state_d = grant_data ? StHoldD : StHoldI;
    end
    // Outputs are forced low while reset is held, independent of requester inputs.
    if (!resetn) grant = 1'b0;
    push  = grant && m_if.addr_ok;
    pop   = resetn && m_if.data_ok && (cnt_q != '0);
    head  = src_q[rd_ptr_q];
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    m_if.req   = grant;
    m_if.wr    = 1'b0;
    m_if.size  = 2'd0;
    m_if.wstrb = 4'd0;
    m_if.addr  = 32'd0;
    m_if.wdata = 32'd0;
    if (grant && grant_data) begin
      m_if.wr    = data_if.wr;
      m_if.size  = data_if.size;
      m_if.wstrb = data_if.wstrb;
      m_if.addr  = data_if.addr;
      m_if.wdata = data_if.wdata;
    end else if (grant) begin
      m_if.size = inst_if.size;
      m_if.addr = inst_if.addr;
    end
    inst_if.addr_ok = push && !grant_data;
    data_if.addr_ok = push && grant_data;
    inst_if.data_ok = pop && !head;
    data_if.data_ok = pop && head;
    inst_if.rdata   = (pop && !head) ? m_if.rdata : 32'd0;
    data_if.rdata   = (pop && head) ? m_if.rdata : 32'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      src_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        src_q[wr_ptr_q] <= grant_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end
endmodule
